// File: rtl/kronos_types.sv
// Shared types for the Kronos front end: the IF->ID pipeline word, the
// PC increment constant and the fetch-unit state encoding.
package kronos_types;

    // Instruction handed from IF to ID: the fetch PC and the raw instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } pipeIFID_t;

    // Sequential PC step; 32-bit addition wraps 32'hFFFF_FFFC to 32'h0.
    localparam logic [31:0] FOUR = 32'd4;

    // FETCH: normal sequential fetch.
    // DRAIN: a redirect arrived while a bus request was in flight. The request
    //        is completed and its data thrown away before the target is fetched.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/kronos_fetch_fifo.sv
// Two-entry response buffer between the instruction bus and ID.
// Flush empties the buffer and takes priority over push and pop in the same
// cycle. Push and pop together leave the occupancy unchanged.
module kronos_fetch_fifo
    import kronos_types::*;
(
    input  logic      clk,
    input  logic      rstz,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  pipeIFID_t din,
    output pipeIFID_t dout,
    output logic      full,
    output logic      empty
);

    pipeIFID_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign dout    = mem[rd_ptr];
    // The fetch unit never pushes into a full buffer or pops an empty one.
    // The gating only keeps the pointers consistent if that promise were broken.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers and occupancy. The entries are cleared by reset so
    // that fetch reads back as zero while reset is held.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/kronos_fetch.sv
// Kronos instruction fetch stage.
// It issues word-aligned requests on a single-outstanding instruction bus and
// buffers the responses in a two-entry FIFO toward ID. It also handles branch
// redirects from EX. A request in flight is never abandoned: a redirect that
// arrives while waiting for an ack moves the unit to DRAIN, where it completes
// the bus cycle, drops the returned word and then resumes at the latest target.
module kronos_fetch
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output pipeIFID_t   fetch,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  target;
    logic [31:0]  target_nxt;
    logic         pending;
    logic         pending_nxt;
    logic         ack_ok;
    logic         push;
    logic         pop;
    logic         flush;
    logic         fifo_full;
    logic         fifo_empty;
    logic [1:0]   occ;
    logic [1:0]   occ_nxt;
    pipeIFID_t    fifo_din;

    // Instruction addresses are always word aligned. The low two bits of any
    // incoming address are cleared.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

    // The request is held in a register, so req and addr stay stable for the
    // whole bus cycle. An ack only counts while a request is actually open.
    // This covers an ack that shows up after reset dropped the request.
    assign instr_req  = pending;
    assign instr_addr = pc;
    assign ack_ok     = pending & instr_ack;

    assign fetch_vld  = ~fifo_empty;
    assign pop        = fetch_vld & fetch_rdy;
    assign fifo_din   = '{pc: pc, ir: instr_data};

    // Current occupancy reconstructed from the FIFO status flags.
    assign occ        = {fifo_full, ~fifo_full & ~fifo_empty};

    // Next-state, next-PC and FIFO control for the two-state fetch FSM.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        target_nxt  = target;
        pending_nxt = pending;
        push        = 1'b0;
        flush       = branch;
        occ_nxt     = 2'd0;

        case (state)
            FETCH: begin
                if (branch) begin
                    if (!pending || ack_ok) begin
                        // Nothing left in flight: redirect at once. Any data
                        // acked this cycle belongs to the wrong path.
                        pc_nxt = word_align(branch_target);
                    end else begin
                        state_nxt  = DRAIN;
                        target_nxt = word_align(branch_target);
                    end
                end else if (ack_ok) begin
                    push   = 1'b1;
                    pc_nxt = pc + FOUR;
                end
            end
            DRAIN: begin
                if (ack_ok) begin
                    // The drained word is dropped. A redirect in this same
                    // cycle is newer than the stored target.
                    state_nxt = FETCH;
                    pc_nxt    = branch ? word_align(branch_target) : target;
                end else if (branch) begin
                    target_nxt = word_align(branch_target);
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        if (flush) begin
            occ_nxt = 2'd0;
        end else begin
            occ_nxt = occ + {1'b0, push} - {1'b0, pop};
        end

        // An open request stays open until it is acked. A new request starts
        // only if its response is sure to find room in the buffer.
        if (pending && !ack_ok) begin
            pending_nxt = 1'b1;
        end else begin
            pending_nxt = (occ_nxt < 2'd2);
        end
    end

    // FSM state, PC, stored redirect target and request-open flag.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state   <= FETCH;
            pc      <= word_align(BOOT_ADDR);
            target  <= 32'h0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            target  <= target_nxt;
            pending <= pending_nxt;
        end
    end

    kronos_fetch_fifo u_fifo (
        .clk   (clk),
        .rstz  (rstz),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (fetch),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_kronos_fetch.sv
// Directed bench for kronos_fetch. Covered: boot fetch, back-pressure,
// redirects (idle, coincident with ack, during DRAIN), PC wrap and reset in
// the middle of a request.
module tb_kronos_fetch;
    import kronos_types::*;

    logic        clk;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic        branch;
    logic [31:0] branch_target;
    pipeIFID_t   fetch;
    logic        fetch_vld;
    logic        fetch_rdy;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [31:0] K = 32'hDEAD_0000;

    kronos_fetch #(.BOOT_ADDR(32'h100)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_data    (instr_data),
        .instr_ack     (instr_ack),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch         (fetch),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory that answers the current request in the same cycle.
    task automatic auto_respond();
        instr_ack  = instr_req;
        instr_data = instr_addr ^ K;
    endtask

    initial begin
        rstz          = 1'b0;
        instr_ack     = 1'b0;
        instr_data    = 32'h0;
        branch        = 1'b0;
        branch_target = 32'h0;
        fetch_rdy     = 1'b1;
        step();
        step();

        // Reset state
        check("rst_req",  32'(instr_req), 32'd0);
        check("rst_vld",  32'(fetch_vld), 32'd0);
        check("rst_pc",   fetch.pc,       32'h0);
        check("rst_ir",   fetch.ir,       32'h0);
        check("rst_addr", instr_addr,     32'h100);

        // Boot: first request right after reset release, ack every cycle
        rstz = 1'b1;
        step();
        check("boot_req",  32'(instr_req), 32'd1);
        check("boot_addr", instr_addr,     32'h100);
        for (int i = 0; i < 3; i++) begin
            auto_respond();
            step();
            check("boot_vld", 32'(fetch_vld), 32'd1);
            check("boot_pc",  fetch.pc, 32'h100 + 32'(4 * i));
            check("boot_ir",  fetch.ir, (32'h100 + 32'(4 * i)) ^ K);
        end

        // Back-pressure: head 0x108 buffered, 0x10C in flight
        fetch_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            auto_respond();
            step();
        end
        instr_ack = 1'b0;
        check("bp_req",  32'(instr_req), 32'd0);
        check("bp_vld",  32'(fetch_vld), 32'd1);
        check("bp_head", fetch.pc,       32'h108);
        fetch_rdy = 1'b1;
        step();
        check("bp_pc2",   fetch.pc,       32'h10C);
        check("bp_ir2",   fetch.ir,       32'h10C ^ K);
        check("bp_req2",  32'(instr_req), 32'd1);
        check("bp_addr2", instr_addr,     32'h110);
        step();
        check("bp_empty", 32'(fetch_vld), 32'd0);
        check("bp_hold",  instr_addr,     32'h110);

        // Redirect to 0x10 coincident with ack
        instr_ack     = 1'b1;
        instr_data    = K;
        branch        = 1'b1;
        branch_target = 32'h10;
        step();
        check("br10_addr", instr_addr,     32'h10);
        check("br10_vld",  32'(fetch_vld), 32'd0);

        // Redirect to 0x200 while 0x10 pending; ack 3 cycles later
        instr_ack     = 1'b0;
        branch_target = 32'h200;
        step();
        branch = 1'b0;
        check("drn_req1",  32'(instr_req), 32'd1);
        check("drn_addr1", instr_addr,     32'h10);
        step();
        check("drn_addr2", instr_addr,     32'h10);
        step();
        check("drn_addr3", instr_addr,     32'h10);
        instr_ack  = 1'b1;
        instr_data = 32'hBAD0_0010;
        step();
        check("drn_next", instr_addr,     32'h200);
        check("drn_drop", 32'(fetch_vld), 32'd0);
        instr_data = 32'h1234_5678;
        step();
        check("drn_vld", 32'(fetch_vld), 32'd1);
        check("drn_pc",  fetch.pc,       32'h200);
        check("drn_ir",  fetch.ir,       32'h1234_5678);

        // Redirect to 0x302 (unaligned) with ack and pop in the same cycle
        instr_data    = 32'h5555_5555;
        branch        = 1'b1;
        branch_target = 32'h302;
        step();
        branch    = 1'b0;
        instr_ack = 1'b0;
        check("co_vld",  32'(fetch_vld), 32'd0);
        check("co_req",  32'(instr_req), 32'd1);
        check("co_addr", instr_addr,     32'h300);

        // Two redirects while draining: the last target wins
        branch        = 1'b1;
        branch_target = 32'h400;
        step();
        check("dd_addr1", instr_addr, 32'h300);
        branch_target = 32'h500;
        step();
        check("dd_addr2", instr_addr, 32'h300);
        branch     = 1'b0;
        instr_ack  = 1'b1;
        instr_data = 32'h6666_6666;
        step();
        check("dd_next", instr_addr,     32'h500);
        check("dd_drop", 32'(fetch_vld), 32'd0);
        instr_data = 32'h5050_5050;
        step();
        check("dd_pc", fetch.pc, 32'h500);
        check("dd_ir", fetch.ir, 32'h5050_5050);

        // PC wrap at the top of the address space
        branch        = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        check("wr_addr", instr_addr, 32'hFFFF_FFFC);
        instr_data = 32'hCAFE_F00D;
        step();
        check("wr_next", instr_addr, 32'h0);
        check("wr_pc",   fetch.pc,   32'hFFFF_FFFC);
        check("wr_ir",   fetch.ir,   32'hCAFE_F00D);

        // Asynchronous reset during an open request
        instr_ack = 1'b0;
        check("ar_pre", 32'(instr_req), 32'd1);
        #2;
        rstz = 1'b0;
        #1;
        check("ar_req", 32'(instr_req), 32'd0);
        check("ar_vld", 32'(fetch_vld), 32'd0);
        instr_ack = 1'b1;
        step();
        step();
        check("ar_hold", 32'(instr_req), 32'd0);
        rstz = 1'b1;
        step();
        check("ar_boot", instr_addr,     32'h100);
        check("ar_req2", 32'(instr_req), 32'd1);
        check("ar_ign",  32'(fetch_vld), 32'd0);
        instr_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
